// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the saturation helpers can describe; callers slice down.
  localparam int RCA_MAX_W = 256;

  function automatic int stages(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic logic [RCA_MAX_W-1:0] MAX_POS(input int width);
    logic [RCA_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [RCA_MAX_W-1:0] MIN_NEG(input int width);
    logic [RCA_MAX_W-1:0] r;
    r = '0;
    r[width-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rca_pipe_adder_if.sv
// Operand/result handshake bundle for rca_pipe_adder; master drives operands.
interface rca_pipe_adder_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, i1, i2, Cin, sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, i1, i2, Cin, sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );

endinterface

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple of full adders; c_msb_in is the carry into the top bit.
module rca_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor, one SEG-bit segment per stage, latency WIDTH/SEG.
// Define RCA_SAT_EN to saturate Sum on signed overflow instead of wrapping.
module rca_pipe_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic           clk,
  input  logic           rst,
  rca_pipe_adder_if.slave bus
);

  localparam int STAGES = stages(WIDTH, SEG);

  if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_cfg
    $error("rca_pipe_adder: WIDTH must be a non-zero multiple of SEG");
  end

`ifdef RCA_SAT_EN
  localparam logic [RCA_MAX_W-1:0] MAX_FULL = MAX_POS(WIDTH);
  localparam logic [RCA_MAX_W-1:0] MIN_FULL = MIN_NEG(WIDTH);
  localparam logic [WIDTH-1:0]     SAT_POS  = MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SAT_NEG  = MIN_FULL[WIDTH-1:0];
`endif

  logic             adv;
  logic [WIDTH-1:0] a_arr [STAGES];
  logic [WIDTH-1:0] b_arr [STAGES];
  logic [WIDTH-1:0] s_arr [STAGES];
  logic             c_arr [STAGES];
  logic             v_arr [STAGES];
  logic             last_co;
  logic             last_cm;
  logic             ovf_q;

  // The whole pipe shifts as one; only a held, unconsumed result stops it.
  assign adv          = !v_arr[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam bit LAST = (k == STAGES - 1);

    logic [WIDTH-1:0] a_in, b_in, s_in, s_nxt;
    logic             c_in, v_in;
    logic [SEG-1:0]   seg_s;
    logic             seg_co, seg_cm;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_q, v_q;

    if (k == 0) begin : g_head
      assign a_in = bus.i1;
      assign b_in = (bus.sub == OP_SUB) ? ~bus.i2 : bus.i2;
      assign s_in = '0;
      assign c_in = (bus.sub == OP_SUB) ? 1'b1 : bus.Cin;
      assign v_in = bus.in_valid;
    end else begin : g_body
      assign a_in = a_arr[k-1];
      assign b_in = b_arr[k-1];
      assign s_in = s_arr[k-1];
      assign c_in = c_arr[k-1];
      assign v_in = v_arr[k-1];
    end

    rca_seg #(.SEG(SEG)) u_seg (
      .a        (a_in[k*SEG +: SEG]),
      .b        (b_in[k*SEG +: SEG]),
      .cin      (c_in),
      .s        (seg_s),
      .cout     (seg_co),
      .c_msb_in (seg_cm)
    );

    always_comb begin
      s_nxt              = s_in;
      s_nxt[k*SEG +: SEG] = seg_s;
`ifdef RCA_SAT_EN
      // Carry out set on overflow means both operands were negative.
      if (LAST && (seg_co ^ seg_cm)) s_nxt = seg_co ? SAT_NEG : SAT_POS;
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        a_q <= a_in;
        b_q <= b_in;
        s_q <= s_nxt;
        c_q <= seg_co;
        v_q <= v_in;
      end
    end

    assign a_arr[k] = a_q;
    assign b_arr[k] = b_q;
    assign s_arr[k] = s_q;
    assign c_arr[k] = c_q;
    assign v_arr[k] = v_q;

    if (LAST) begin : g_tail
      assign last_co = seg_co;
      assign last_cm = seg_cm;
    end else begin : g_mid
      logic unused_cm;
      assign unused_cm = seg_cm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      ovf_q <= 1'b0;
    else if (adv) ovf_q <= last_co ^ last_cm;
  end

  // Operand bits leaving the final stage have nowhere further to go.
  logic unused_tail;
  assign unused_tail = ^{a_arr[STAGES-1], b_arr[STAGES-1]};

  assign bus.out_valid = v_arr[STAGES-1];
  assign bus.Sum       = s_arr[STAGES-1];
  assign bus.Cout      = c_arr[STAGES-1];
  assign bus.Ovf       = ovf_q;

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Directed-vector bench for rca_pipe_adder at WIDTH=16, SEG=4 (latency 4).
module tb_rca_pipe_adder;
  import rca_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rca_pipe_adder_if #(.WIDTH(16)) bus ();

  rca_pipe_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
  } res_t;

  res_t outq[$];
  int   accq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.in_valid && bus.in_ready) accq.push_back(cyc);
      if (bus.out_valid && bus.out_ready) outq.push_back('{bus.Sum, bus.Cout, bus.Ovf, cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic op);
    bus.i1       = a;
    bus.i2       = b;
    bus.Cin      = cin;
    bus.sub      = op;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [15:0] s, input logic c,
                            input logic o, input bit lat);
    res_t r;
    for (int n = 0; n < 40 && outq.size() == 0; n++) @(posedge clk);
    if (outq.size() == 0) begin
      chk({tag, "_timeout"}, 32'(outq.size()), 32'd1);
      return;
    end
    r = outq.pop_front();
    chk({tag, "_sum"}, 32'(r.s), 32'(s));
    chk({tag, "_cout"}, 32'(r.c), 32'(c));
    chk({tag, "_ovf"}, 32'(r.o), 32'(o));
    if (lat) begin
      if (accq.size() == 0) chk({tag, "_acc_missing"}, 32'(accq.size()), 32'd1);
      else chk({tag, "_latency"}, 32'(r.t - accq.pop_front()), 32'd4);
    end
  endtask

  // Back-pressure stream: operands and hand-computed results.
  logic [15:0] bp_a [8] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000,
                            16'h7FFF, 16'hFFFF, 16'h1234, 16'h8000};
  logic [15:0] bp_b [8] = '{16'h0001, 16'h0020, 16'h0300, 16'h4000,
                            16'h0001, 16'hFFFF, 16'h1111, 16'h8000};
`ifdef RCA_SAT_EN
  logic [15:0] bp_s [8] = '{16'h0002, 16'h0030, 16'h0400, 16'h5000,
                            16'h7FFF, 16'hFFFE, 16'h2345, 16'h8000};
`else
  logic [15:0] bp_s [8] = '{16'h0002, 16'h0030, 16'h0400, 16'h5000,
                            16'h8000, 16'hFFFE, 16'h2345, 16'h0000};
`endif
  logic        bp_c [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        bp_o [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.i1        = 16'hAAAA;
    bus.i2        = 16'h5555;
    bus.Cin       = 1'b1;
    bus.sub       = OP_ADD;
    bus.out_ready = 1'b1;

    // Reset held three cycles with operands offered.
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.Sum), 32'd0);
    chk("rst_cout", 32'(bus.Cout), 32'd0);
    chk("rst_ovf", 32'(bus.Ovf), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (8) @(posedge clk);
    chk("rst_no_result", 32'(outq.size()), 32'd0);

    #1; accq.delete(); outq.delete();
    send(16'h1234, 16'h0FED, 1'b1, OP_ADD);
    bus.in_valid = 1'b0;
    expect_res("add", 16'h2222, 1'b0, 1'b0, 1'b1);

    #1; accq.delete(); outq.delete();
    send(16'hFFFF, 16'h0001, 1'b0, OP_ADD);
    bus.in_valid = 1'b0;
    expect_res("ripple", 16'h0000, 1'b1, 1'b0, 1'b1);

    #1; accq.delete(); outq.delete();
    send(16'h0005, 16'h0007, 1'b1, OP_SUB);
    bus.in_valid = 1'b0;
    expect_res("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b1);

    #1; accq.delete(); outq.delete();
    send(16'h8000, 16'h0001, 1'b0, OP_SUB);
    bus.in_valid = 1'b0;
`ifdef RCA_SAT_EN
    expect_res("sub_ovf", 16'h8000, 1'b1, 1'b1, 1'b1);
`else
    expect_res("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b1);
`endif

    // Eight back-to-back ops, consumer stalls in cycles 6..9 holding op 2.
    @(posedge clk);
    #1; accq.delete(); outq.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_a[i], bp_b[i], 1'b0, OP_ADD);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
          chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
          chk("bp_hold_sum", 32'(bus.Sum), 32'h0400);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 8; i++) expect_res($sformatf("bp%0d", i), bp_s[i], bp_c[i], bp_o[i], 1'b0);
    repeat (6) @(posedge clk);
    chk("bp_no_extra", 32'(outq.size()), 32'd0);

    // Reset pulse with three ops in flight.
    #1; accq.delete(); outq.delete();
    send(16'h1111, 16'h1111, 1'b0, OP_ADD);
    send(16'h2222, 16'h2222, 1'b0, OP_ADD);
    send(16'h3333, 16'h3333, 1'b0, OP_ADD);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("mid_rst_stale", 32'(outq.size()), 32'd0);
    #1; accq.delete(); outq.delete();
    send(16'h0F0F, 16'h00F1, 1'b0, OP_ADD);
    bus.in_valid = 1'b0;
    expect_res("post_rst", 16'h1000, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
